t05_htree_sequencer: RTL and testbench

T05_HTREE_SEQUENCER -- requirements
Module: t05_htree_sequencer

---
 rtl/t05_huff_pkg.sv | 20 ++
 rtl/t05_htree_sequencer.sv | 179 +++++++++++++++++
 tb/tb_t05_htree_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t05_huff_pkg.sv
// Shared types and constants for the Huffman tree-build sequencer.
package t05_huff_pkg;

   localparam int NODE_BASE  = 256;  // first weight-table address of an internal node
   localparam int MAX_LEAVES = 129;  // most leaves whose tree fits in the node table
   localparam int SCAN_LEN   = 384;  // weight-table entries per scan (256 leaves + 128 nodes)
   localparam int WDOG_MAX   = 400;  // SCAN cycles allowed before the build is abandoned

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      SCAN   = 3'd2,
      CHECK  = 3'd3,
      WIPE1  = 3'd4,
      WIPE2  = 3'd5,
      WRITE  = 3'd6,
      FINISH = 3'd7
   } state_e;

endpackage

// File: rtl/t05_htree_sequencer.sv
// Huffman tree-build sequencer: repeatedly asks an external least-value
// scanner for the two lightest weight-table entries, zeroes them, writes
// their sum as a new internal node, and stops after leaf_count-1 merges.
//
// Handshake: start is a single-cycle request that is accepted only in IDLE;
// busy is high from the cycle after acceptance until the done pulse has been
// issued, and any start seen while busy is dropped without side effects.
module t05_htree_sequencer
   import t05_huff_pkg::*;
#(
   parameter int SCAN_LEN = t05_huff_pkg::SCAN_LEN,
   parameter int WDOG_MAX = t05_huff_pkg::WDOG_MAX
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [8:0]   leaf_count,
   input  logic         flv_fin,
   input  logic [8:0]   flv_least1,
   input  logic [8:0]   flv_least2,
   input  logic [63:0]  flv_sum,
   output logic         flv_en,
   output logic         flv_clr,
   output logic         wt_wr_en,
   output logic [8:0]   wt_wr_addr,
   output logic [63:0]  wt_wr_data,
   output logic         node_wr_en,
   output logic [6:0]   node_addr,
   output logic [81:0]  node_data,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [7:0]   node_cnt,
   output state_e       dbg_state
);

   // A shorter weight table leaves room for fewer internal nodes, so the leaf limit shrinks with it.
   localparam int LEAF_FIT   = SCAN_LEN - NODE_BASE + 1;
   localparam int LEAF_LIMIT = (LEAF_FIT < MAX_LEAVES) ? LEAF_FIT : MAX_LEAVES;
   localparam int WD_W       = $clog2(WDOG_MAX + 1);

   state_e            state_q, state_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
   logic [7:0]        node_cnt_q, node_cnt_d;
   logic [8:0]        leaf_q, leaf_d;
   logic [8:0]        l1_q, l1_d;
   logic [8:0]        l2_q, l2_d;
   logic [63:0]       sum_q, sum_d;
   logic [WD_W-1:0]   wd_inc;

   assign wd_inc = wd_q + WD_W'(1);

   // State and datapath registers; reset returns everything to an idle, empty build.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wd_q       <= '0;
         err_q      <= 1'b0;
         node_cnt_q <= '0;
         leaf_q     <= '0;
         l1_q       <= '0;
         l2_q       <= '0;
         sum_q      <= '0;
      end else begin
         state_q    <= state_d;
         wd_q       <= wd_d;
         err_q      <= err_d;
         node_cnt_q <= node_cnt_d;
         leaf_q     <= leaf_d;
         l1_q       <= l1_d;
         l2_q       <= l2_d;
         sum_q      <= sum_d;
      end
   end

   // Next-state and register updates for one merge round per CLEAR..WRITE pass.
   always_comb begin
      state_d    = state_q;
      wd_d       = wd_q;
      err_d      = err_q;
      node_cnt_d = node_cnt_q;
      leaf_d     = leaf_q;
      l1_d       = l1_q;
      l2_d       = l2_q;
      sum_d      = sum_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               err_d      = 1'b0;
               node_cnt_d = '0;
               leaf_d     = leaf_count;
               if (leaf_count == 9'd0 || leaf_count > 9'(LEAF_LIMIT)) begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end else if (leaf_count == 9'd1) begin
                  state_d = FINISH;
               end else begin
                  state_d = CLEAR;
               end
            end
         end
         CLEAR: begin
            wd_d    = '0;
            state_d = SCAN;
         end
         SCAN: begin
            wd_d = wd_inc;
            if (flv_fin) begin
               state_d = CHECK;
            end else if (wd_inc == WD_W'(WDOG_MAX)) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end
         end
         CHECK: begin
            l1_d  = flv_least1;
            l2_d  = flv_least2;
            sum_d = flv_sum;
            // Equal indices or a zero sum mean the table held fewer than two live entries.
            if (flv_least1 == flv_least2 || flv_sum == 64'd0) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else begin
               state_d = WIPE1;
            end
         end
         WIPE1: state_d = WIPE2;
         WIPE2: state_d = WRITE;
         WRITE: begin
            node_cnt_d = (node_cnt_q == 8'd128) ? node_cnt_q : node_cnt_q + 8'd1;
            if ({1'b0, node_cnt_d} == leaf_q - 9'd1) state_d = FINISH;
            else                                   state_d = CLEAR;
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs: write strobes only in WIPE1, WIPE2 and WRITE, one weight write per cycle.
   always_comb begin
      flv_en     = 1'b0;
      flv_clr    = 1'b0;
      wt_wr_en   = 1'b0;
      wt_wr_addr = '0;
      wt_wr_data = '0;
      node_wr_en = 1'b0;
      node_addr  = '0;
      node_data  = '0;
      case (state_q)
         CLEAR: flv_clr = 1'b1;
         SCAN:  flv_en  = 1'b1;
         WIPE1: begin
            wt_wr_en   = 1'b1;
            wt_wr_addr = l1_q;
         end
         WIPE2: begin
            wt_wr_en   = 1'b1;
            wt_wr_addr = l2_q;
         end
         WRITE: begin
            wt_wr_en   = 1'b1;
            wt_wr_addr = 9'(NODE_BASE) | {2'b00, node_cnt_q[6:0]};
            wt_wr_data = sum_q;
            node_wr_en = 1'b1;
            node_addr  = node_cnt_q[6:0];
            node_data  = {l1_q, l2_q, sum_q};
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FINISH);
   assign err       = err_q;
   assign node_cnt  = node_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_t05_htree_sequencer.sv
// Bench for the Huffman tree-build sequencer, with a behavioural weight
// table and least-value scanner standing in for the parent-level blocks.
module tb_t05_htree_sequencer;
   import t05_huff_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [8:0]   leaf_count;
   logic         flv_fin;
   logic [8:0]   flv_least1;
   logic [8:0]   flv_least2;
   logic [63:0]  flv_sum;
   logic         flv_en;
   logic         flv_clr;
   logic         wt_wr_en;
   logic [8:0]   wt_wr_addr;
   logic [63:0]  wt_wr_data;
   logic         node_wr_en;
   logic [6:0]   node_addr;
   logic [81:0]  node_data;
   logic         busy;
   logic         done;
   logic         err;
   logic [7:0]   node_cnt;
   state_e       dbg_state;

   t05_htree_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .leaf_count(leaf_count),
      .flv_fin(flv_fin), .flv_least1(flv_least1), .flv_least2(flv_least2),
      .flv_sum(flv_sum), .flv_en(flv_en), .flv_clr(flv_clr),
      .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
      .node_wr_en(node_wr_en), .node_addr(node_addr), .node_data(node_data),
      .busy(busy), .done(done), .err(err), .node_cnt(node_cnt),
      .dbg_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Weight table and its reload image
   logic [63:0] tbl      [0:383];
   logic [63:0] init_tbl [0:383];
   logic        load_req = 1'b0;

   // Scanner model state
   int          scan_mode = 0;   // 0 normal, 1 never finishes, 2 reports equal indices
   int          tgt_q[$];
   int          cur_tgt = 2;
   int          en_cnt  = 0;
   logic        fin_r   = 1'b0;
   logic [8:0]  l1_r    = '0;
   logic [8:0]  l2_r    = '0;
   logic [63:0] sum_r   = '0;
   int          sa, sb;

   assign flv_fin    = fin_r;
   assign flv_least1 = l1_r;
   assign flv_least2 = l2_r;
   assign flv_sum    = sum_r;

   // Scoreboard
   logic [72:0] exp_wt_q[$];
   logic [88:0] exp_node_q[$];
   logic [72:0] obs_wt_q[$];
   logic [88:0] obs_node_q[$];
   int          busy_cyc = 0;
   int          en_cyc   = 0;
   int          done_cnt = 0;

   // Lightest live entry (lowest index on ties) and the next lightest.
   function automatic void pick2(input logic [63:0] w[0:383], output int a, output int b);
      a = -1;
      b = -1;
      for (int i = 0; i < 384; i++)
         if (w[i] != 0 && (a < 0 || w[i] < w[a])) a = i;
      for (int i = 0; i < 384; i++)
         if (i != a && w[i] != 0 && (b < 0 || w[i] < w[b])) b = i;
   endfunction

   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < 384; i++) tbl[i] <= init_tbl[i];
      end else if (wt_wr_en) begin
         tbl[wt_wr_addr] <= wt_wr_data;
      end
   end

   always @(posedge clk) begin
      if (flv_clr) begin
         fin_r   <= 1'b0;
         en_cnt  <= 0;
         cur_tgt <= (tgt_q.size() > 0) ? tgt_q.pop_front() : 2;
      end else if (flv_en && !fin_r) begin
         en_cnt <= en_cnt + 1;
         if (scan_mode != 1 && en_cnt + 1 == cur_tgt) begin
            pick2(tbl, sa, sb);
            if (sa < 0) sa = 0;
            if (sb < 0) sb = sa;
            fin_r <= 1'b1;
            l1_r  <= 9'(sa);
            l2_r  <= (scan_mode == 2) ? 9'(sa) : 9'(sb);
            sum_r <= tbl[sa] + tbl[sb];
         end
      end
   end

   // Monitor: records every write and counts busy/scan/done cycles
   always @(negedge clk) begin
      if (busy)       busy_cyc <= busy_cyc + 1;
      if (flv_en)     en_cyc   <= en_cyc + 1;
      if (done)       done_cnt <= done_cnt + 1;
      if (wt_wr_en)   obs_wt_q.push_back({wt_wr_addr, wt_wr_data});
      if (node_wr_en) obs_node_q.push_back({node_addr, node_data});
   end

   // Driver helpers
   task automatic clear_init();
      for (int i = 0; i < 384; i++) init_tbl[i] = '0;
   endtask

   task automatic load_table();
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
   endtask

   // Reference model: full sequence of merges from the reload image.
   task automatic build_model(input int n);
      logic [63:0] w [0:383];
      int a, b;
      logic [63:0] s;
      exp_wt_q.delete();
      exp_node_q.delete();
      for (int i = 0; i < 384; i++) w[i] = init_tbl[i];
      for (int k = 0; k < n - 1; k++) begin
         pick2(w, a, b);
         s = w[a] + w[b];
         exp_wt_q.push_back({9'(a), 64'd0});
         exp_wt_q.push_back({9'(b), 64'd0});
         exp_wt_q.push_back({9'(256 + k), s});
         exp_node_q.push_back({7'(k), 9'(a), 9'(b), s});
         w[a] = '0;
         w[b] = '0;
         w[256 + k] = s;
      end
   endtask

   // Queue scanner latencies; each merge costs CLEAR + (tgt+1) scan cycles + 4.
   task automatic push_tgts(input int merges, input int lo, input int hi, output int busy_exp);
      int t;
      busy_exp = 1;
      for (int m = 0; m < merges; m++) begin
         t = $urandom_range(hi, lo);
         tgt_q.push_back(t);
         busy_exp += t + 6;
      end
   endtask

   task automatic run_and_check(input string name, input logic [8:0] leaf, input logic exp_err,
                                input logic [7:0] exp_nodes, input int exp_busy, input bit noise,
                                output int en_delta);
      int b0, d0, w0, n0, e0;
      bit seen;
      b0 = busy_cyc; d0 = done_cnt; w0 = obs_wt_q.size(); n0 = obs_node_q.size(); e0 = en_cyc;
      @(negedge clk); #1;
      leaf_count = leaf;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6000 && !seen; c++) begin
         if (done_cnt != d0) seen = 1'b1;
         else begin
            if (noise) start = ($urandom_range(5, 0) == 0);
            @(negedge clk); #1;
         end
      end
      start = 1'b0;
      n_tests++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s timeout: no done within budget", name);
      end
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_tests++;
      if (done_cnt - d0 !== 1) begin
         n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0);
      end
      n_tests++;
      if (err !== exp_err) begin
         n_fail++; $display("FAIL %s err: got %b expected %b", name, err, exp_err);
      end
      n_tests++;
      if (node_cnt !== exp_nodes) begin
         n_fail++; $display("FAIL %s node_cnt: got %0d expected %0d", name, node_cnt, exp_nodes);
      end
      n_tests++;
      if (busy_cyc - b0 !== exp_busy) begin
         n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cyc - b0, exp_busy);
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL %s busy_after: got %b expected 0", name, busy);
      end
      n_tests++;
      if (obs_wt_q.size() - w0 !== exp_wt_q.size()) begin
         n_fail++;
         $display("FAIL %s wt_write_count: got %0d expected %0d", name, obs_wt_q.size() - w0, exp_wt_q.size());
      end
      for (int i = 0; i < exp_wt_q.size() && w0 + i < obs_wt_q.size(); i++) begin
         n_tests++;
         if (obs_wt_q[w0 + i] !== exp_wt_q[i]) begin
            n_fail++;
            $display("FAIL %s wt_write[%0d]: got addr %0d data %0h expected addr %0d data %0h", name, i,
                     obs_wt_q[w0 + i][72:64], obs_wt_q[w0 + i][63:0], exp_wt_q[i][72:64], exp_wt_q[i][63:0]);
         end
      end
      n_tests++;
      if (obs_node_q.size() - n0 !== exp_node_q.size()) begin
         n_fail++;
         $display("FAIL %s node_write_count: got %0d expected %0d", name, obs_node_q.size() - n0, exp_node_q.size());
      end
      for (int i = 0; i < exp_node_q.size() && n0 + i < obs_node_q.size(); i++) begin
         n_tests++;
         if (obs_node_q[n0 + i] !== exp_node_q[i]) begin
            n_fail++;
            $display("FAIL %s node_write[%0d]: got %0h expected %0h", name, i, obs_node_q[n0 + i], exp_node_q[i]);
         end
      end
      en_delta = en_cyc - e0;
   endtask

   task automatic check_quiet(input string name);
      n_tests++;
      if (busy !== 0 || done !== 0 || err !== 0 || node_cnt !== 0 || wt_wr_en !== 0 || node_wr_en !== 0 ||
          flv_en !== 0 || flv_clr !== 0 || wt_wr_addr !== 0 || wt_wr_data !== 0 || node_addr !== 0 ||
          node_data !== 0 || dbg_state !== IDLE) begin
         n_fail++;
         $display("FAIL %s outputs: got busy=%b done=%b err=%b node_cnt=%0d wt_wr_en=%b node_wr_en=%b flv_en=%b flv_clr=%b state=%0d expected all 0 and IDLE",
                  name, busy, done, err, node_cnt, wt_wr_en, node_wr_en, flv_en, flv_clr, dbg_state);
      end
   endtask

   // Tests
   task automatic test_reset();
      int w0;
      rst = 1'b1; start = 1'b0; leaf_count = '0;
      clear_init();
      repeat (3) @(negedge clk);
      #1;
      check_quiet("reset_held");
      w0 = obs_wt_q.size();
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check_quiet("reset_released");
      n_tests++;
      if (obs_wt_q.size() !== w0) begin
         n_fail++; $display("FAIL reset_no_writes: got %0d expected %0d", obs_wt_q.size(), w0);
      end
   endtask

   task automatic test_two_leaves();
      int be, en;
      clear_init();
      init_tbl[10]  = 64'd3;
      init_tbl[200] = 64'd5;
      load_table();
      build_model(2);
      push_tgts(1, 1, 4, be);
      run_and_check("two_leaves", 9'd2, 1'b0, 8'd1, be, 1'b0, en);
   endtask

   task automatic test_four_leaves();
      int be, en;
      clear_init();
      init_tbl[3] = 64'd1; init_tbl[7] = 64'd1; init_tbl[20] = 64'd2; init_tbl[50] = 64'd4;
      load_table();
      build_model(4);
      push_tgts(3, 1, 5, be);
      run_and_check("four_leaves", 9'd4, 1'b0, 8'd3, be, 1'b0, en);
   endtask

   task automatic test_wide_sum();
      int be, en;
      clear_init();
      init_tbl[0]   = 64'h4000_0000_0000_0001;
      init_tbl[255] = 64'h7000_0000_0000_0003;
      load_table();
      build_model(2);
      push_tgts(1, 2, 2, be);
      run_and_check("wide_sum", 9'd2, 1'b0, 8'd1, be, 1'b0, en);
   endtask

   task automatic test_random_builds();
      int be, en, n, idx;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(24, 2);
         clear_init();
         for (int j = 0; j < n; j++) begin
            do idx = $urandom_range(255, 0); while (init_tbl[idx] != 0);
            if (it % 2 == 0) init_tbl[idx] = 64'($urandom_range(100000, 1));
            else             init_tbl[idx] = ({32'($urandom), 32'($urandom)} >> 6) | 64'd1;
         end
         load_table();
         build_model(n);
         push_tgts(n - 1, 1, 6, be);
         run_and_check($sformatf("random_%0d", it), 9'(n), 1'b0, 8'(n - 1), be, 1'b1, en);
      end
   endtask

   task automatic test_single_leaf();
      int en;
      clear_init();
      init_tbl[42] = 64'd9;
      load_table();
      build_model(1);
      run_and_check("single_leaf", 9'd1, 1'b0, 8'd0, 1, 1'b0, en);
   endtask

   task automatic test_bad_count();
      int en;
      build_model(1);
      run_and_check("leaf_200", 9'd200, 1'b1, 8'd0, 1, 1'b0, en);
      run_and_check("leaf_0", 9'd0, 1'b1, 8'd0, 1, 1'b0, en);
      run_and_check("leaf_130", 9'd130, 1'b1, 8'd0, 1, 1'b0, en);
   endtask

   task automatic test_watchdog();
      int en, be;
      clear_init();
      init_tbl[1] = 64'd2; init_tbl[2] = 64'd3; init_tbl[3] = 64'd4;
      load_table();
      build_model(1);
      scan_mode = 1;
      push_tgts(1, 1, 1, be);
      run_and_check("watchdog", 9'd3, 1'b1, 8'd0, 402, 1'b0, en);
      scan_mode = 0;
      n_tests++;
      if (en !== 400) begin
         n_fail++; $display("FAIL watchdog_scan_cycles: got %0d expected 400", en);
      end
      n_tests++;
      if (dbg_state !== IDLE) begin
         n_fail++; $display("FAIL watchdog_idle: got %0d expected %0d", dbg_state, IDLE);
      end
   endtask

   task automatic test_check_error();
      int en, be;
      clear_init();
      init_tbl[5] = 64'd7; init_tbl[6] = 64'd8;
      load_table();
      build_model(1);
      scan_mode = 2;
      push_tgts(1, 3, 3, be);
      run_and_check("equal_indices", 9'd2, 1'b1, 8'd0, 7, 1'b0, en);
      scan_mode = 0;
      n_tests++;
      if (en !== 4) begin
         n_fail++; $display("FAIL equal_indices_scan_cycles: got %0d expected 4", en);
      end
   endtask

   task automatic test_reset_mid_write();
      int be, en, w0;
      bit hit;
      clear_init();
      init_tbl[11] = 64'd6; init_tbl[12] = 64'd2; init_tbl[13] = 64'd9;
      load_table();
      tgt_q.delete();
      push_tgts(2, 2, 2, be);
      @(negedge clk); #1;
      leaf_count = 9'd3;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         if (dbg_state == WIPE2) hit = 1'b1;
         else begin @(negedge clk); #1; end
      end
      n_tests++;
      if (!hit) begin
         n_fail++; $display("FAIL reset_mid_reach_wipe2: got state %0d expected %0d", dbg_state, WIPE2);
      end
      #1 rst = 1'b1;
      #1;
      check_quiet("reset_mid_wipe2");
      @(negedge clk); #1;
      rst = 1'b0;
      tgt_q.delete();
      w0 = obs_wt_q.size();
      repeat (10) @(negedge clk);
      #1;
      n_tests++;
      if (obs_wt_q.size() !== w0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_quiet: got %0d writes busy=%b expected 0 writes busy=0", obs_wt_q.size() - w0, busy);
      end
      load_table();
      build_model(3);
      push_tgts(2, 1, 4, be);
      run_and_check("rebuild_after_reset", 9'd3, 1'b0, 8'd2, be, 1'b0, en);
   endtask

   initial begin
      test_reset();
      test_two_leaves();
      test_four_leaves();
      test_wide_sum();
      test_single_leaf();
      test_bad_count();
      test_watchdog();
      test_check_error();
      test_random_builds();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
